// File: rtl/synthesijer_tb_pkg.sv
// rtl/synthesijer_tb_pkg.sv - state and result encodings for the method test runner
package synthesijer_tb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_PASS,
        RES_FAIL,
        RES_TIMEOUT
    } result_t;

endpackage

// File: rtl/method_test_runner_if.sv
// rtl/method_test_runner_if.sv - request/busy/return port of one generated boolean method
interface method_test_runner_if;

    logic m_req;
    logic m_busy;
    logic m_return;

    modport master (
        output m_req,
        input  m_busy,
        input  m_return
    );

    modport slave (
        input  m_req,
        output m_busy,
        output m_return
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         at_max
);

    assign at_max = &q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && !at_max) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/method_test_runner.sv
// rtl/method_test_runner.sv - issues one method call after a delay and records its outcome
module method_test_runner
    import synthesijer_tb_pkg::*;
#(
    parameter int unsigned START_DELAY = 100,
    parameter int unsigned ACK_WINDOW  = 8,
    parameter int unsigned TIMEOUT     = 200000000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    method_test_runner_if.master m,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timed_out,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_WINDOW - 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    state_t  state_q, state_d;
    result_t result_q, result_d;

    logic [CNT_W-1:0] dly_q, ack_q, cyc_q;
    logic dly_clr, dly_inc, ack_clr, ack_inc, cyc_clr, cyc_inc;
    logic dly_max, ack_max, cyc_max;

    sat_counter #(.W(CNT_W)) u_dly (
        .clk(clk), .reset(reset), .clr(dly_clr), .inc(dly_inc), .q(dly_q), .at_max(dly_max)
    );
    sat_counter #(.W(CNT_W)) u_ack (
        .clk(clk), .reset(reset), .clr(ack_clr), .inc(ack_inc), .q(ack_q), .at_max(ack_max)
    );
    sat_counter #(.W(CNT_W)) u_cyc (
        .clk(clk), .reset(reset), .clr(cyc_clr), .inc(cyc_inc), .q(cyc_q), .at_max(cyc_max)
    );

    // Saturation is handled inside the counters; the flags are not needed here.
    logic unused_max;
    assign unused_max = &{1'b0, dly_max, ack_max, cyc_max};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= RES_NONE;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        dly_clr  = 1'b1;
        dly_inc  = 1'b0;
        ack_clr  = 1'b1;
        ack_inc  = 1'b0;
        cyc_clr  = 1'b0;
        cyc_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                cyc_clr = 1'b1;
                if (enable) begin
                    dly_clr = 1'b0;
                    if (dly_q == DLY_LAST) state_d = REQ;
                    else                   dly_inc = 1'b1;
                end
            end
            REQ: begin
                ack_clr = 1'b0;
                cyc_inc = 1'b1;
                if (m.m_busy) begin
                    state_d = RUN;
                end else if (ack_q == ACK_LAST) begin
                    state_d  = DONE;
                    result_d = RES_TIMEOUT;
                end else begin
                    ack_inc = 1'b1;
                end
            end
            RUN: begin
                // Completion is checked first so a busy fall on the timeout cycle still reports a result.
                if (!m.m_busy) begin
                    state_d  = DONE;
                    result_d = m.m_return ? RES_PASS : RES_FAIL;
                end else if (TO_EN && (cyc_q == TO_LIMIT)) begin
                    state_d  = DONE;
                    result_d = RES_TIMEOUT;
                end else begin
                    cyc_inc = 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m.m_req      = (state_q == REQ);
    assign done         = (state_q == DONE);
    assign pass         = (result_q == RES_PASS);
    assign fail         = (result_q == RES_FAIL);
    assign timed_out    = (result_q == RES_TIMEOUT);
    assign cycle_count  = cyc_q;

endmodule
